// File: rtl/hps_bus_responder.sv
// HPS-to-MIPS bridge responder: memory window below 0x800000, ID/CTRL/STATUS/SCRATCH registers above.
// Optional macro HPS_BUS_TIMEOUT_EN aborts stalled memory accesses after TIMEOUT_CYCLES.
module hps_bus_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ID_VALUE       = 32'h4D495053
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [23:0] avalon_address,
    input  logic [3:0]  avalon_byte_enable,
    input  logic        avalon_read,
    input  logic        avalon_write,
    input  logic [31:0] avalon_write_data,
    output logic        avalon_acknowledge,
    output logic [31:0] avalon_read_data,
    output logic [20:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        cpu_hold
);

    typedef enum logic [1:0] {IDLE, MEM, ACK, DROP} state_t;

    state_t      state_q, state_d;
    logic [23:2] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        wr_q, wr_d;
    logic [31:0] memdata_q, memdata_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mem_re_q, mem_re_d;
    logic        mem_we_q, mem_we_d;
    logic [20:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        hold_q, hold_d;
    logic [31:0] scratch_q, scratch_d;
    logic        status_bit;
    logic [31:0] reg_rdata;
    logic        unused_bits;

`ifdef HPS_BUS_TIMEOUT_EN
    localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          status_q, status_d;
    assign status_bit  = status_q;
    assign unused_bits = ^avalon_address[1:0];
`else
    assign status_bit  = 1'b0;
    assign unused_bits = ^{avalon_address[1:0], TIMEOUT_CYCLES[0]};
`endif

    assign avalon_acknowledge = ack_q;
    assign avalon_read_data   = rdata_q;
    assign mem_re             = mem_re_q;
    assign mem_we             = mem_we_q;
    assign mem_addr           = mem_addr_q;
    assign mem_wdata          = mem_wdata_q;
    assign mem_be             = mem_be_q;
    assign cpu_hold           = hold_q;

    always_comb begin
        reg_rdata = '0;
        case (addr_q[22:2])
            21'd0:   reg_rdata = ID_VALUE;
            21'd1:   reg_rdata = {31'd0, hold_q};
            21'd2:   reg_rdata = {31'd0, status_bit};
            21'd3:   reg_rdata = scratch_q;
            default: reg_rdata = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        wr_d        = wr_q;
        memdata_d   = memdata_q;
        ack_d       = 1'b0;
        rdata_d     = '0;
        mem_re_d    = mem_re_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        hold_d      = hold_q;
        scratch_d   = scratch_q;
`ifdef HPS_BUS_TIMEOUT_EN
        cnt_d       = cnt_q;
        status_d    = status_q;
`endif
        case (state_q)
            IDLE: begin
                if (avalon_read || avalon_write) begin
                    addr_d  = avalon_address[23:2];
                    wdata_d = avalon_write_data;
                    be_d    = avalon_byte_enable;
                    wr_d    = avalon_write;
                    if (avalon_address[23]) begin
                        state_d = ACK;
                    end else begin
                        state_d     = MEM;
                        mem_addr_d  = avalon_address[22:2];
                        mem_wdata_d = avalon_write_data;
                        mem_be_d    = avalon_byte_enable;
                        mem_we_d    = avalon_write;
                        mem_re_d    = ~avalon_write;
`ifdef HPS_BUS_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end
                end
            end
            MEM: begin
                if (mem_ready) begin
                    mem_re_d  = 1'b0;
                    mem_we_d  = 1'b0;
                    memdata_d = mem_rdata;
                    state_d   = ACK;
`ifdef HPS_BUS_TIMEOUT_EN
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    // last stalled cycle: abort with a recognisable poison value
                    mem_re_d  = 1'b0;
                    mem_we_d  = 1'b0;
                    memdata_d = 32'hDEADBEEF;
                    status_d  = 1'b1;
                    state_d   = ACK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            ACK: begin
                ack_d   = 1'b1;
                state_d = DROP;
                if (!wr_q) begin
                    rdata_d = addr_q[23] ? reg_rdata : memdata_q;
                end else if (addr_q[23]) begin
                    case (addr_q[22:2])
                        21'd1: if (be_q[0]) hold_d = wdata_q[0];
`ifdef HPS_BUS_TIMEOUT_EN
                        21'd2: if (be_q[0] && wdata_q[0]) status_d = 1'b0;
`endif
                        21'd3: begin
                            for (int unsigned i = 0; i < 4; i++) begin
                                if (be_q[i]) scratch_d[8*i +: 8] = wdata_q[8*i +: 8];
                            end
                        end
                        default: ;
                    endcase
                end
            end
            DROP: begin
                if (!avalon_read && !avalon_write) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            wr_q        <= 1'b0;
            memdata_q   <= '0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            hold_q      <= 1'b1;
            scratch_q   <= '0;
`ifdef HPS_BUS_TIMEOUT_EN
            cnt_q       <= '0;
            status_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            wr_q        <= wr_d;
            memdata_q   <= memdata_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            hold_q      <= hold_d;
            scratch_q   <= scratch_d;
`ifdef HPS_BUS_TIMEOUT_EN
            cnt_q       <= cnt_d;
            status_q    <= status_d;
`endif
        end
    end

endmodule

// File: tb/tb_hps_bus_responder.sv
// Directed bench for hps_bus_responder: register map, memory handshake, held strobes, reset abort.
module tb_hps_bus_responder;

    logic        clock;
    logic        resetn;
    logic [23:0] avalon_address;
    logic [3:0]  avalon_byte_enable;
    logic        avalon_read;
    logic        avalon_write;
    logic [31:0] avalon_write_data;
    logic        avalon_acknowledge;
    logic [31:0] avalon_read_data;
    logic [20:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        cpu_hold;

    int checks = 0;
    int errors = 0;

    // memory-side model and event counters
    int          mem_lat    = 3;
    bit          mem_stuck  = 1'b0;
    int          mem_cnt    = 0;
    int          ack_cnt    = 0;
    int          re_cycles  = 0;
    int          we_bursts  = 0;
    logic        prev_we    = 1'b0;
    logic [20:0] seen_addr  = '0;
    logic [31:0] seen_wdata = '0;
    logic [3:0]  seen_be    = '0;

    hps_bus_responder #(.TIMEOUT_CYCLES(255), .ID_VALUE(32'h4D495053)) dut (
        .clock              (clock),
        .resetn             (resetn),
        .avalon_address     (avalon_address),
        .avalon_byte_enable (avalon_byte_enable),
        .avalon_read        (avalon_read),
        .avalon_write       (avalon_write),
        .avalon_write_data  (avalon_write_data),
        .avalon_acknowledge (avalon_acknowledge),
        .avalon_read_data   (avalon_read_data),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_be             (mem_be),
        .mem_we             (mem_we),
        .mem_re             (mem_re),
        .mem_rdata          (mem_rdata),
        .mem_ready          (mem_ready),
        .cpu_hold           (cpu_hold)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        #1;
        if (avalon_acknowledge) ack_cnt++;
        if (mem_we && !prev_we) we_bursts++;
        prev_we = mem_we;
        if (mem_re || mem_we) begin
            if (mem_re) re_cycles++;
            seen_addr  = mem_addr;
            seen_wdata = mem_wdata;
            seen_be    = mem_be;
            mem_cnt++;
            mem_ready  = (mem_cnt == mem_lat) && !mem_stuck;
        end else begin
            mem_cnt   = 0;
            mem_ready = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // strobe held until acknowledge, then optionally held `hold` extra cycles
    task automatic xfer(input logic rd, input logic wr, input logic [23:0] a, input logic [31:0] d,
                        input logic [3:0] be, input int hold,
                        output logic [31:0] rdata, output int lat);
        avalon_address     = a;
        avalon_write_data  = d;
        avalon_byte_enable = be;
        avalon_read        = rd;
        avalon_write       = wr;
        lat = 0;
        while (lat < 600) begin
            tick();
            lat++;
            if (avalon_acknowledge) break;
        end
        rdata = avalon_read_data;
        chk("ack_seen", {31'd0, avalon_acknowledge}, 32'd1);
        repeat (hold) tick();
        avalon_read  = 1'b0;
        avalon_write = 1'b0;
        tick();
        tick();
    endtask

    logic [31:0] rd;
    int          lat;
    int          a0, r0, w0;

    initial begin
        resetn             = 1'b0;
        avalon_address     = '0;
        avalon_byte_enable = '0;
        avalon_read        = 1'b0;
        avalon_write       = 1'b0;
        avalon_write_data  = '0;
        mem_rdata          = '0;
        mem_ready          = 1'b0;
        tick();
        tick();
        chk("rst_ack", {31'd0, avalon_acknowledge}, 32'd0);
        chk("rst_rdata", avalon_read_data, 32'd0);
        chk("rst_re_we", {30'd0, mem_re, mem_we}, 32'd0);
        chk("rst_addr", {11'd0, mem_addr}, 32'd0);
        chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
        resetn = 1'b1;
        tick();

        xfer(1'b1, 1'b0, 24'h800000, 32'h0, 4'hF, 0, rd, lat);
        chk("id_data", rd, 32'h4D495053);
        chk("id_lat", lat, 32'd2);

        xfer(1'b0, 1'b1, 24'h80000C, 32'h12345678, 4'b0101, 0, rd, lat);
        chk("scr_wr_rdata", rd, 32'd0);
        xfer(1'b1, 1'b0, 24'h80000C, 32'h0, 4'hF, 0, rd, lat);
        chk("scr_be", rd, 32'h00340078);

        // read+write together is a write
        xfer(1'b1, 1'b1, 24'h80000F, 32'hAABBCCDD, 4'hF, 0, rd, lat);
        chk("rw_as_wr_rdata", rd, 32'd0);
        xfer(1'b1, 1'b0, 24'h80000C, 32'h0, 4'hF, 0, rd, lat);
        chk("scr_full", rd, 32'hAABBCCDD);

        xfer(1'b1, 1'b0, 24'h800004, 32'h0, 4'hF, 0, rd, lat);
        chk("ctrl_rst", rd, 32'd1);
        xfer(1'b0, 1'b1, 24'h800004, 32'hFFFFFFFE, 4'b1110, 0, rd, lat);
        chk("ctrl_be_skip", {31'd0, cpu_hold}, 32'd1);
        xfer(1'b0, 1'b1, 24'h800004, 32'h0, 4'b0001, 0, rd, lat);
        chk("ctrl_clr", {31'd0, cpu_hold}, 32'd0);
        xfer(1'b1, 1'b0, 24'h800004, 32'h0, 4'hF, 0, rd, lat);
        chk("ctrl_rd", rd, 32'd0);

        xfer(1'b0, 1'b1, 24'h800010, 32'hFFFFFFFF, 4'hF, 0, rd, lat);
        chk("unmap_wr_lat", lat, 32'd2);
        xfer(1'b1, 1'b0, 24'h800010, 32'h0, 4'hF, 0, rd, lat);
        chk("unmap_rd", rd, 32'd0);

        // memory read, ready on third strobe cycle
        mem_lat = 3; mem_rdata = 32'hCAFEF00D;
        a0 = ack_cnt; r0 = re_cycles;
        xfer(1'b1, 1'b0, 24'h000010, 32'h0, 4'hF, 0, rd, lat);
        chk("mem_rd_data", rd, 32'hCAFEF00D);
        chk("mem_rd_addr", {11'd0, seen_addr}, 32'd4);
        chk("mem_rd_recyc", re_cycles - r0, 32'd3);
        chk("mem_rd_lat", lat, 32'd5);
        chk("mem_rd_acks", ack_cnt - a0, 32'd1);

        // memory write with strobe held past acknowledge
        mem_lat = 2;
        a0 = ack_cnt; w0 = we_bursts;
        xfer(1'b0, 1'b1, 24'h000023, 32'h5A5AA5A5, 4'b1001, 5, rd, lat);
        chk("mem_wr_rdata", rd, 32'd0);
        chk("mem_wr_lat", lat, 32'd4);
        chk("mem_wr_addr", {11'd0, seen_addr}, 32'd8);
        chk("mem_wr_data", seen_wdata, 32'h5A5AA5A5);
        chk("mem_wr_be", {28'd0, seen_be}, 32'h9);
        chk("mem_wr_bursts", we_bursts - w0, 32'd1);
        chk("mem_wr_acks", ack_cnt - a0, 32'd1);
        chk("mem_wr_idle", {30'd0, mem_re, mem_we}, 32'd0);

`ifdef HPS_BUS_TIMEOUT_EN
        mem_stuck = 1'b1;
        xfer(1'b1, 1'b0, 24'h000100, 32'h0, 4'hF, 0, rd, lat);
        chk("tmo_data", rd, 32'hDEADBEEF);
        chk("tmo_lat", lat, 32'd257);
        mem_stuck = 1'b0;
        xfer(1'b1, 1'b0, 24'h800008, 32'h0, 4'hF, 0, rd, lat);
        chk("tmo_status", rd, 32'd1);
        xfer(1'b0, 1'b1, 24'h800008, 32'h1, 4'hF, 0, rd, lat);
        xfer(1'b1, 1'b0, 24'h800008, 32'h0, 4'hF, 0, rd, lat);
        chk("tmo_status_clr", rd, 32'd0);
`else
        xfer(1'b1, 1'b0, 24'h800008, 32'h0, 4'hF, 0, rd, lat);
        chk("status_zero", rd, 32'd0);
`endif

        // reset during a stalled memory read
        mem_stuck = 1'b1;
        avalon_address = 24'h000100; avalon_byte_enable = 4'hF; avalon_read = 1'b1;
        tick(); tick(); tick();
        chk("abort_re_pre", {31'd0, mem_re}, 32'd1);
        chk("abort_addr_pre", {11'd0, mem_addr}, 32'h40);
        a0 = ack_cnt;
        resetn = 1'b0;
        #1;
        chk("abort_re", {31'd0, mem_re}, 32'd0);
        chk("abort_ack", {31'd0, avalon_acknowledge}, 32'd0);
        chk("abort_hold", {31'd0, cpu_hold}, 32'd1);
        chk("abort_addr", {11'd0, mem_addr}, 32'd0);
        tick(); tick();
        chk("abort_no_ack", ack_cnt - a0, 32'd0);
        resetn = 1'b1;
        mem_stuck = 1'b0; mem_lat = 2; mem_rdata = 32'h0BADF00D;
        lat = 0;
        while (lat < 600) begin
            tick();
            lat++;
            if (avalon_acknowledge) break;
        end
        chk("rerun_data", avalon_read_data, 32'h0BADF00D);
        chk("rerun_lat", lat, 32'd4);
        chk("rerun_acks", ack_cnt - a0, 32'd1);
        avalon_read = 1'b0;
        tick(); tick();
        xfer(1'b1, 1'b0, 24'h80000C, 32'h0, 4'hF, 0, rd, lat);
        chk("scr_after_rst", rd, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
